// File: rtl/code_key_transmitter_if.sv
// Button/display bundle between the code key transmitter and whatever drives it.
// The master side raises start/load and supplies the code; the slave side is the transmitter.
interface code_key_transmitter_if #(
    parameter int CODE_LEN = 5
);
    logic                start;
    logic                load;
    logic [CODE_LEN-1:0] code_in;
    logic                zero_out;
    logic                one_out;
    logic                busy;
    logic                done;
    logic [6:0]          seg7;
    logic [2:0]          enable;

    modport master (
        output start, load, code_in,
        input  zero_out, one_out, busy, done, seg7, enable
    );

    modport slave (
        input  start, load, code_in,
        output zero_out, one_out, busy, done, seg7, enable
    );
endinterface

// File: rtl/code_key_transmitter.sv
// Replays a stored unlock code, MSB first, as timed pulses on separate zero/one lines
// that drive the lock's buttons, with a 7-segment digit counting the bits fully sent.
module code_key_transmitter #(
    parameter int                  CODE_LEN     = 5,
    parameter logic [CODE_LEN-1:0] CODE_DEFAULT = 5'b01011,
    parameter int                  TICK_DIV     = 10000000,
    parameter int                  PULSE_TICKS  = 2,
    parameter int                  GAP_TICKS    = 2
) (
    input  logic                   clk_100Mhz,
    input  logic                   reset,
    code_key_transmitter_if.slave  bus
);

    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW       = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int CW       = $clog2(CODE_LEN + 1);
    localparam int MAX_PH   = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
    localparam int PHW      = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP,
        FINISH
    } state_t;

    state_t              state;
    logic [1:0]          start_sync;
    logic [1:0]          load_sync;
    logic                start_prev;
    logic                load_prev;
    logic                start_evt;
    logic                load_evt;
    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic                leave_idle;
    logic [PHW-1:0]      phase_cnt;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       sent;
    logic [CODE_LEN-1:0] code;

    function automatic logic [6:0] seg_digit(input logic [CW-1:0] n);
        case (int'(n))
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            default: return 7'b1111111;
        endcase
    endfunction

    // Events are registered one stage past the edge flop; this sets the start-to-pulse latency.
    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            start_sync <= '0;
            load_sync  <= '0;
            start_prev <= 1'b0;
            load_prev  <= 1'b0;
            start_evt  <= 1'b0;
            load_evt   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the shift stages read each other's old values.
            start_sync <= {start_sync[0], bus.start};
            load_sync  <= {load_sync[0], bus.load};
            start_prev <= start_sync[1];
            load_prev  <= load_sync[1];
            start_evt  <= start_sync[1] & ~start_prev;
            load_evt   <= load_sync[1] & ~load_prev;
        end
    end

    assign leave_idle = (state == IDLE) && start_evt;
    assign tick       = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk_100Mhz) begin
        if (reset || leave_idle || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Outputs are registered from the current state, so every output lags the state by one cycle.
    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            phase_cnt    <= '0;
            sent         <= '0;
            // NOTE: the code register is reset, since the default key must be usable right after reset.
            code         <= CODE_DEFAULT;
            bus.zero_out <= 1'b0;
            bus.one_out  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.seg7     <= 7'b1000000;
        end else begin
            bus.zero_out <= (state == DRIVE) && !code[idx];
            bus.one_out  <= (state == DRIVE) && code[idx];
            bus.busy     <= (state == DRIVE) || (state == GAP);
            bus.done     <= (state == FINISH);
            bus.seg7     <= seg_digit(sent);

            case (state)
                IDLE: begin
                    // A simultaneous load lands in the same edge, so DRIVE already sees the new code.
                    if (load_evt) begin
                        code <= bus.code_in;
                    end
                    if (start_evt) begin
                        state     <= DRIVE;
                        idx       <= IW'(CODE_LEN - 1);
                        phase_cnt <= '0;
                        sent      <= '0;
                    end
                end
                DRIVE: begin
                    if (tick) begin
                        if (phase_cnt == PHW'(PULSE_TICKS - 1)) begin
                            phase_cnt <= '0;
                            state     <= GAP;
                        end else begin
                            phase_cnt <= phase_cnt + PHW'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (phase_cnt == PHW'(GAP_TICKS - 1)) begin
                            phase_cnt <= '0;
                            sent      <= sent + CW'(1);
                            if (idx == '0) begin
                                state <= FINISH;
                            end else begin
                                idx   <= idx - IW'(1);
                                state <= DRIVE;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + PHW'(1);
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.enable = 3'b110;

endmodule

// File: tb/tb_code_key_transmitter.sv
// Self-checking bench for code_key_transmitter: directed scenarios plus random codes,
// compared cycle by cycle against a waveform model computed from bit timing arithmetic.
module tb_code_key_transmitter;

    localparam int CODE_LEN    = 5;
    localparam int TICK_DIV    = 4;
    localparam int PULSE_TICKS = 2;
    localparam int GAP_TICKS   = 1;
    localparam int PER         = (PULSE_TICKS + GAP_TICKS) * TICK_DIV;
    localparam int TOTAL       = CODE_LEN * PER;

    logic clk_100Mhz = 1'b0;
    logic reset      = 1'b1;
    int   checks     = 0;
    int   errors     = 0;
    int   tx_num     = 0;

    code_key_transmitter_if #(.CODE_LEN(CODE_LEN)) bus ();

    code_key_transmitter #(
        .CODE_LEN    (CODE_LEN),
        .CODE_DEFAULT(5'b01011),
        .TICK_DIV    (TICK_DIV),
        .PULSE_TICKS (PULSE_TICKS),
        .GAP_TICKS   (GAP_TICKS)
    ) dut (
        .clk_100Mhz(clk_100Mhz),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] digit(input int n);
        case (n)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            default: return 7'b1111111;
        endcase
    endfunction

    // {zero_out, one_out, busy, done, seg7} expected i cycles after the first pulse edge.
    function automatic logic [10:0] exp_at(input logic [4:0] c, input int i);
        int   b;
        bit   pulse;
        logic bv;
        if (i < TOTAL) begin
            b     = i / PER;
            pulse = (i % PER) < PULSE_TICKS * TICK_DIV;
            bv    = c[CODE_LEN-1-b];
            return {pulse & ~bv, pulse & bv, 1'b1, 1'b0, digit(b)};
        end
        if (i == TOTAL) return {4'b0001, digit(CODE_LEN)};
        return {4'b0000, digit(CODE_LEN)};
    endfunction

    function automatic logic [10:0] observed();
        return {bus.zero_out, bus.one_out, bus.busy, bus.done, bus.seg7};
    endfunction

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_100Mhz);
            check($sformatf("tx%0d_idle%0d", tx_num, k),
                  {bus.zero_out, bus.one_out, bus.busy, bus.done}, 4'b0000);
        end
    endtask

    task automatic run_tx(input logic [4:0] c, input int hold, input int restart_at,
                          input int busy_load_at, input int reset_at, input int sim_load_hold);
        int cyc  = 0;
        int n    = 0;
        bit seen = 0;
        tx_num++;
        bus.start = 1'b1;
        bus.load  = (sim_load_hold > 0);
        while (!seen && n < 12) begin
            @(negedge clk_100Mhz);
            n++;
            cyc++;
            if (bus.busy) seen = 1;
            bus.start = (cyc < hold);
            bus.load  = (cyc < sim_load_hold);
        end
        check($sformatf("tx%0d_latency", tx_num), n, 5);
        if (!seen) begin
            bus.start = 1'b0;
            bus.load  = 1'b0;
            return;
        end
        for (int i = 0; i <= TOTAL + 1; i++) begin
            if (i > 0) begin
                @(negedge clk_100Mhz);
                cyc++;
            end
            check($sformatf("tx%0d_c%0d", tx_num, i), observed(), exp_at(c, i));
            if (i == reset_at) begin
                bus.start = 1'b0;
                bus.load  = 1'b0;
                reset     = 1'b1;
                @(negedge clk_100Mhz);
                check($sformatf("tx%0d_abort", tx_num), observed(), {4'b0000, 7'b1000000});
                reset = 1'b0;
                return;
            end
            bus.start = (cyc < hold) || (restart_at >= 0 && i >= restart_at && i < restart_at + 3);
            bus.load  = (cyc < sim_load_hold) ||
                        (busy_load_at >= 0 && i >= busy_load_at && i < busy_load_at + 3);
        end
        bus.start = 1'b0;
        bus.load  = 1'b0;
    endtask

    task automatic load_pulse(input logic [4:0] v);
        @(negedge clk_100Mhz);
        bus.code_in = v;
        bus.load    = 1'b1;
        repeat (3) @(negedge clk_100Mhz);
        bus.load = 1'b0;
        repeat (5) @(negedge clk_100Mhz);
    endtask

    initial begin
        logic [4:0] model_code;
        logic [4:0] v;
        model_code  = 5'b01011;
        bus.start   = 1'b0;
        bus.load    = 1'b0;
        bus.code_in = '0;
        reset       = 1'b1;
        repeat (3) @(negedge clk_100Mhz);
        check("reset_outputs", observed(), {4'b0000, 7'b1000000});
        check("enable", bus.enable, 3'b110);
        reset = 1'b0;
        repeat (3) @(negedge clk_100Mhz);

        // Default code with start held for 20 cycles.
        run_tx(model_code, 20, -1, -1, -1, 0);
        idle_check(6);

        // A second start edge mid-transmission is neither honoured nor queued.
        run_tx(model_code, 3, 10, -1, -1, 0);
        idle_check(8);

        // Load during busy is ignored, now and for the next transmission.
        bus.code_in = 5'b00000;
        run_tx(model_code, 3, -1, 20, -1, 0);
        idle_check(6);
        run_tx(model_code, 3, -1, -1, -1, 0);
        idle_check(6);

        // Load a new code, then reset during the third bit restores the default.
        load_pulse(5'b11100);
        model_code = 5'b11100;
        run_tx(model_code, 2, -1, -1, 26, 0);
        model_code = 5'b01011;
        idle_check(8);
        run_tx(model_code, 2, -1, -1, -1, 0);
        idle_check(4);

        load_pulse(5'b11100);
        model_code = 5'b11100;
        run_tx(model_code, 4, -1, -1, -1, 0);
        idle_check(4);

        // Start and load rising together: the new code is sent.
        bus.code_in = 5'b10101;
        model_code  = 5'b10101;
        run_tx(model_code, 3, -1, -1, -1, 3);
        idle_check(4);

        for (int r = 0; r < 6; r++) begin
            v = 5'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk_100Mhz);
            if ($urandom_range(0, 1) == 1) begin
                bus.code_in = v;
                model_code  = v;
                run_tx(model_code, $urandom_range(1, 8), -1, -1, -1, 2);
            end else begin
                load_pulse(v);
                model_code = v;
                run_tx(model_code, $urandom_range(1, 8), -1, -1, -1, 0);
            end
            idle_check(4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_key_transmitter.md
Name: code_key_transmitter

Overview:
Transmit side of the two-button sequence lock. On a start request, the block replays a stored N-bit unlock code as timed level pulses on separate zero/one lines. These lines wire directly to the lock's zero/one button inputs. It drives a 7-segment digit showing bits sent, plus busy/done status. Used as an automatic key for board demos and as a stimulus source for lock verification.

Parameters:
CODE_LEN, 5, number of code bits sent per transmission.
CODE_DEFAULT, 5'b01011, code loaded at reset; the MSB is sent first.
TICK_DIV, 10000000, clk_100Mhz cycles per timing tick (board default 0.1 s).
PULSE_TICKS, 2, ticks a zero_out/one_out level is held per bit (min 1).
GAP_TICKS, 2, ticks with both lines low after each bit (min 1).

Ports:
clk_100Mhz  input  1  system clock, single clock domain.
reset  input  1  synchronous, active-high reset.
start  input  1  raw button level; a rising edge requests a transmission.
load  input  1  raw switch level; a rising edge while idle captures code_in.
code_in  input  CODE_LEN  code to store on load; the MSB is the first bit sent.
zero_out  output  1  high while a '0' bit is being sent.
one_out  output  1  high while a '1' bit is being sent.
busy  output  1  high from transmission start until done.
done  output  1  one-cycle pulse after the final gap.
seg7  output  7  active-low digit showing the count of bits fully sent.
enable  output  3  digit enables; constant 3'b110.

Behaviour:
- Clocking and reset: the whole block runs on clk_100Mhz. Reset is synchronous and active-high, sampled on the clock edge.
- Values while reset is high:
  - state = IDLE.
  - zero_out, one_out, busy and done = 0.
  - Bit counter = 0, so seg7 = 7'b1000000.
  - Code register = CODE_DEFAULT.
  - Tick counter = 0.
  - Synchronizer flops = 0.
- Reset mid-transmission aborts immediately on that edge. No further pulse is emitted and done is not asserted.
- Input conditioning: start and load each pass through a 2-flop synchronizer plus an edge flop. A rise event is the synchronized level high while the previous synchronized level is low. A held level generates exactly one event.
- Tick generator:
  - The counter runs 0..TICK_DIV-1; tick = 1 for one cycle when count == TICK_DIV-1, then the counter wraps.
  - The counter is cleared to 0 on the cycle the FSM leaves IDLE, so bit timing is aligned to start.
- FSM states: IDLE, DRIVE, GAP, FINISH. All outputs are registered.
  - IDLE, on a start rise event: go to DRIVE.
    - Load the bit index with CODE_LEN-1.
    - Clear the tick counter and the ticks-in-phase counter.
    - Set busy = 1.
  - DRIVE: zero_out = ~code[idx], one_out = code[idx]; never both high.
    - After PULSE_TICKS ticks, go to GAP.
  - GAP: zero_out = one_out = 0.
    - After GAP_TICKS ticks, increment the bits-sent count.
    - If idx == 0, go to FINISH; otherwise decrement idx and go to DRIVE.
  - FINISH (one cycle): done = 1, busy = 0, then go to IDLE.
- Latency: the first pulse level rises on the 4th clock edge after the first edge that samples start = 1.
- Timing per bit:
  - Pulse width is exactly PULSE_TICKS*TICK_DIV cycles.
  - Gap width is exactly GAP_TICKS*TICK_DIV cycles.
  - A whole transmission occupies CODE_LEN*(PULSE_TICKS+GAP_TICKS)*TICK_DIV cycles of busy, followed by the done cycle.
- Start and load rules:
  - A start rise event while busy or in FINISH is ignored; it is not queued.
  - A load rise event while not in IDLE is ignored.
  - Start and load rising in the same IDLE cycle: the load takes effect first, and the transmission sends the newly loaded code.
- seg7 shows the bits-sent count, using the codebase digit encoding:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100.
  - 3 = 0110000, 4 = 0011001, 5 = 0010010.
  - Counts above 5 display 1111111.
- The count is held after done until the next accepted start, which zeroes it.

Test Plan:
All scenarios use TICK_DIV=4, PULSE_TICKS=2, GAP_TICKS=1.
1. Reset, then start held high for 20 cycles.
   - Expected bit order 0,1,0,1,1: zero_out, one_out, zero_out, one_out, one_out.
   - Each pulse is 8 cycles wide, with a 4-cycle all-low gap after every bit.
   - busy is high for 60 cycles, then done pulses once; seg7 ends at 0010010.
2. Idle, pulse load with code_in = 5'b11100, then start.
   - Expected: one_out, one_out, one_out, zero_out, zero_out; never both lines high.
3. Second start edge 10 cycles into a transmission: exactly 5 bits are sent and only one done pulse occurs.
4. Load edge during busy with code_in = 5'b00000: the current transmission still sends 01011, and the next start also sends 01011.
5. Reset asserted during the 3rd bit's DRIVE:
   - On the next edge: zero_out = one_out = busy = 0 and seg7 = 1000000, with no done pulse.
   - Code register = 01011.
6. Start and load rising in the same cycle with code_in = 5'b10101: the transmission sends 1,0,1,0,1.
